reg_files_sb: RTL and testbench
===============================

# reg_files_sb

Parametrised multi-read-port integer register file with an integrated busy-bit scoreboard for the RV32IM pipeline's ID stage. It provides NRP combinational read ports with optional write-to-read bypass and a hardwired-zero x0. Per-register pending flags are set at issue and cleared at writeback, so the hazard unit can stall on long-latency M-extension results (MUL/DIV). It replaces the fixed 2-read/1-write register file and adds pending-count and stale-writeback status.

## Interface
Parameters:
- XLEN, 32, data width in bits
- AW, 5, address width; depth = 2^AW registers
- NRP, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value only

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- raddr  input  NRP*AW  read addresses; port i at bits [i*AW +: AW]
- rdata  output  NRP*XLEN  read data; port i at bits [i*XLEN +: XLEN]
- rbusy  output  NRP  1 = register at port i still has a pending producer
- we  input  1  writeback enable
- waddr  input  AW  writeback address
- wd  input  XLEN  writeback data
- iss_valid  input  1  an instruction with a destination issues this cycle
- iss_addr  input  AW  destination of the issuing instruction
- flush  input  1  pipeline flush; clears all busy bits
- pend_cnt  output  AW+1  number of registers currently marked busy
- wr_stale  output  1  one-cycle pulse: the previous cycle wrote a non-zero register that was not busy

## Operation
- Storage: 2^AW x XLEN array plus a 2^AW busy vector. Register 0 always reads 0, is never busy, and ignores writes and issues.
- Write: on the clock edge, if we=1 and waddr!=0, reg[waddr] <= wd and busy[waddr] is cleared.
- Issue: on the clock edge, if iss_valid=1, iss_addr!=0 and flush=0, busy[iss_addr] <= 1.
- Issue and write to the same address in the same cycle: data is written and the busy bit ends at 1 (the new producer wins).
- Flush: all busy bits are cleared on the edge, and any issue in the same cycle is ignored. A same-cycle write still updates data.
- Read port i is combinational:
  - raddr=0: rdata=0, rbusy=0.
  - BYPASS=1 and we=1 and waddr==raddr!=0: rdata=wd, and rbusy=busy[raddr] & ~1 = 0. Issue is not bypassed.
  - Otherwise: rdata=reg[raddr], rbusy=busy[raddr].
- pend_cnt: registered; always equals the popcount of the busy vector after the same edge. Range 0..2^AW-1, never wraps.
- wr_stale: registered. It is set to 1 on an edge where we=1, waddr!=0 and busy[waddr]=0 before the edge; otherwise it is 0. This is a diagnostic only and does not block the write.

## Timing
- Reset (rst=0, asynchronous): all registers 0, busy vector 0, pend_cnt=0, wr_stale=0. rdata is 0 and rbusy is 0 on all ports while in reset.
- Release: the first edge after rst returns high performs normal updates. A reset asserted mid-operation aborts pending state immediately, with no clock required.
- Write latency: 1 edge to the array. With BYPASS=1, the value is visible on a matching read port in the same cycle. With BYPASS=0, it is visible the cycle after the edge.
- Issue latency: rbusy for the destination rises in the cycle after the issue edge.
- All NRP read ports are independent. Identical addresses on several ports return identical data and busy.

## Test plan
- Reset: drive rst=0 mid-run after writes. Require all rdata=0, pend_cnt=0 and wr_stale=0 with no clock edge. After release, reading x5 returns 0.
- Write/read with bypass: we=1, waddr=5, wd=32'h12345678, raddr0=5, raddr1=10. In the same cycle require rdata0=12345678 (BYPASS=1). Next cycle, with we=0, rdata0 is unchanged and rdata1=0. Repeat with BYPASS=0: same cycle rdata0=0, next cycle 12345678.
- x0 protection: we=1, waddr=0, wd=FFFFFFFF; iss_valid=1, iss_addr=0. Require rdata=0, rbusy=0, pend_cnt=0 and wr_stale=0 on the following cycle.
- Scoreboard lifecycle:
  - Issue x10, then x11. Require pend_cnt=1, then 2, and rbusy=1 on port reading x10.
  - Write x10 with ABCDEF12. Require rbusy=0 in the write cycle (bypass), pend_cnt=1 after the edge, and wr_stale=0.
- Simultaneous events:
  - Issue and write x7 in the same cycle: busy[7]=1 after the edge and data stored.
  - Flush together with issue of x8: all busy=0, pend_cnt=0, and x8 not busy.
- Stale writeback: write x3 with 0xDEAD while not busy. Require wr_stale=1 for exactly one cycle and reg[3]=DEAD.

Source files
------------

// File: rtl/reg_files_sb.sv
// Multi-read-port integer register file with a per-register busy scoreboard.
// Tracks pending producers between issue and writeback for ID-stage hazard stalls.
module reg_files_sb #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NRP    = 2,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRP*AW-1:0]     raddr,
  output logic [NRP*XLEN-1:0]   rdata,
  output logic [NRP-1:0]        rbusy,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wd,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_addr,
  input  logic                  flush,
  output logic [AW:0]           pend_cnt,
  output logic                  wr_stale
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [XLEN-1:0]  mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;
  logic             wr_hit;
  logic [AW-1:0]    ra;

  assign wr_hit = we && (waddr != '0);

  // Writeback clears first so a same-cycle issue to that register leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_hit)
      busy_nxt[waddr] = 1'b0;
    if (flush)
      busy_nxt = '0;
    else if (iss_valid && (iss_addr != '0))
      busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[AW'(i)]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[AW'(i)] <= '0;
      busy     <= '0;
      pend_cnt <= '0;
      wr_stale <= 1'b0;
    end else begin
      if (wr_hit)
        mem[waddr] <= wd;
      busy     <= busy_nxt;
      pend_cnt <= cnt_nxt;
      wr_stale <= wr_hit && !busy[waddr];
    end
  end

  // Read ports are forced to zero during reset so a bypassed wd cannot leak out.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      ra = raddr[p*AW +: AW];
      if (rst && (ra != '0)) begin
        if ((BYPASS != 0) && wr_hit && (waddr == ra)) begin
          rdata[p*XLEN +: XLEN] = wd;
          rbusy[p]              = 1'b0;
        end else begin
          rdata[p*XLEN +: XLEN] = mem[ra];
          rbusy[p]              = busy[ra];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_files_sb.sv
// Scoreboard bench for reg_files_sb: bypass and non-bypass instances share stimulus,
// expectations come from an array-based model and are checked by a separate monitor.
module tb_reg_files_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  raddr = '0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wd = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic        flush = 1'b0;

  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic [5:0]  pend_b, pend_n;
  logic        stale_b, stale_n;

  always #5 clk = ~clk;

  reg_files_sb #(.XLEN(32), .AW(5), .NRP(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .we(we), .waddr(waddr), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .flush(flush), .pend_cnt(pend_b), .wr_stale(stale_b)
  );

  reg_files_sb #(.XLEN(32), .AW(5), .NRP(2), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .we(we), .waddr(waddr), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .flush(flush), .pend_cnt(pend_n), .wr_stale(stale_n)
  );

  typedef struct packed {
    logic [1:0][1:0][31:0] rd;   // [variant: 1=bypass, 0=no bypass][port]
    logic [1:0][1:0]       rb;
    logic [5:0]            pc;
    logic                  st;
  } exp_t;

  exp_t q[$];

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_reg  [32];
  logic        m_busy [32];
  logic        m_stale;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_stale = 1'b0;
  endtask

  function automatic int model_pending();
    int n = 0;
    for (int i = 0; i < 32; i++)
      if (m_busy[i]) n++;
    return n;
  endfunction

  task automatic cyc(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] d,
                     input logic iv, input logic [4:0] ia, input logic fl,
                     input logic [4:0] a0, input logic [4:0] a1);
    exp_t e;
    logic [4:0] a;
    @(negedge clk);
    rst = r; we = w; waddr = wa; wd = d; iss_valid = iv; iss_addr = ia; flush = fl;
    raddr = {a1, a0};
    #1;
    if (!r) model_reset();
    for (int v = 0; v < 2; v++) begin
      for (int p = 0; p < 2; p++) begin
        a = (p == 0) ? a0 : a1;
        if (!r || a == 0) begin
          e.rd[v][p] = '0;
          e.rb[v][p] = 1'b0;
        end else if (v == 1 && w && wa == a) begin
          e.rd[v][p] = d;
          e.rb[v][p] = 1'b0;
        end else begin
          e.rd[v][p] = m_reg[a];
          e.rb[v][p] = m_busy[a];
        end
      end
    end
    e.pc = 6'(model_pending());
    e.st = m_stale;
    q.push_back(e);
    if (r) begin
      m_stale = w && wa != 0 && !m_busy[wa];
      if (w && wa != 0) begin
        m_reg[wa]  = d;
        m_busy[wa] = 1'b0;
      end
      if (fl) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (iv && ia != 0) begin
        m_busy[ia] = 1'b1;
      end
    end
  endtask

  // Monitor: compares one queued expectation per cycle, just before the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("byp.rdata0",   rdata_b[31:0],  e.rd[1][0]);
        chk("byp.rdata1",   rdata_b[63:32], e.rd[1][1]);
        chk("byp.rbusy0",   32'(rbusy_b[0]), 32'(e.rb[1][0]));
        chk("byp.rbusy1",   32'(rbusy_b[1]), 32'(e.rb[1][1]));
        chk("byp.pend_cnt", 32'(pend_b),     32'(e.pc));
        chk("byp.wr_stale", 32'(stale_b),    32'(e.st));
        chk("nobyp.rdata0", rdata_n[31:0],  e.rd[0][0]);
        chk("nobyp.rdata1", rdata_n[63:32], e.rd[0][1]);
        chk("nobyp.rbusy0", 32'(rbusy_n[0]), 32'(e.rb[0][0]));
        chk("nobyp.rbusy1", 32'(rbusy_n[1]), 32'(e.rb[0][1]));
        chk("nobyp.pend_cnt", 32'(pend_n),   32'(e.pc));
        chk("nobyp.wr_stale", 32'(stale_n),  32'(e.st));
      end
    end
  end

  initial begin
    model_reset();
    // r  we wa   wd             iv ia  fl  a0  a1
    cyc(0, 0, 0,  32'h0,         0, 0,  0,  5,  10);
    cyc(1, 0, 0,  32'h0,         0, 0,  0,  5,  10);
    cyc(1, 1, 5,  32'h12345678,  0, 0,  0,  5,  10);
    cyc(1, 0, 0,  32'h0,         0, 0,  0,  5,  10);
    cyc(1, 1, 0,  32'hFFFFFFFF,  1, 0,  0,  0,  0);
    cyc(1, 0, 0,  32'h0,         0, 0,  0,  0,  0);
    cyc(1, 0, 0,  32'h0,         1, 10, 0,  10, 11);
    cyc(1, 0, 0,  32'h0,         1, 11, 0,  10, 11);
    cyc(1, 0, 0,  32'h0,         0, 0,  0,  10, 11);
    cyc(1, 1, 10, 32'hABCDEF12,  0, 0,  0,  10, 11);
    cyc(1, 0, 0,  32'h0,         0, 0,  0,  10, 11);
    cyc(1, 1, 7,  32'h00000777,  1, 7,  0,  7,  11);
    cyc(1, 0, 0,  32'h0,         0, 0,  0,  7,  8);
    cyc(1, 0, 0,  32'h0,         1, 8,  1,  7,  8);
    cyc(1, 0, 0,  32'h0,         0, 0,  0,  7,  8);
    cyc(1, 1, 3,  32'h0000DEAD,  0, 0,  0,  3,  5);
    cyc(1, 0, 0,  32'h0,         0, 0,  0,  3,  5);
    cyc(1, 0, 0,  32'h0,         0, 0,  0,  3,  5);
    cyc(1, 1, 9,  32'hCAFE0009,  1, 12, 0,  9,  12);
    cyc(1, 1, 12, 32'h0BADF00D,  0, 0,  0,  5,  12);
    cyc(0, 1, 5,  32'h55555555,  0, 0,  0,  5,  12);
    cyc(1, 0, 0,  32'h0,         0, 0,  0,  5,  12);
    cyc(1, 0, 0,  32'h0,         0, 0,  0,  5,  3);
    for (int n = 0; n < 500; n++) begin
      cyc(($urandom_range(0, 63) != 0),
          ($urandom_range(0, 1) == 1),
          5'($urandom_range(0, 15)),
          $urandom,
          ($urandom_range(0, 9) < 4),
          5'($urandom_range(0, 15)),
          ($urandom_range(0, 15) == 0),
          5'($urandom_range(0, 15)),
          5'($urandom_range(0, 15)));
    end
    cyc(1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
